// File: rtl/face_ctrl_sched.sv
// face_ctrl_sched: frame-synchronous configuration scheduler for vga_face.
// Collects face/filter requests, auto-cycle timing and microphone activity
// and only ever updates face_select / filter_mode / mic_en on the clock edge
// that accepts the last beat of a frame, so each frame renders with a single
// consistent configuration.
module face_ctrl_sched #(
  parameter int NUM_FACES   = 3,
  parameter int NUM_FILTERS = 3,
  parameter int AUTO_FRAMES = 60,
  parameter int MIC_HANG    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_face,
  input  logic       req_filter,
  input  logic       auto_en,
  input  logic       mic_active,
  input  logic       vid_eop,
  input  logic       vid_valid,
  input  logic       vid_ready,
  output logic [1:0] face_select,
  output logic [2:0] filter_mode,
  output logic       mic_en,
  output logic       frame_tick,
  output logic       synced
);

  localparam int FC_W   = $clog2(AUTO_FRAMES + 1);
  localparam int HANG_W = $clog2(MIC_HANG + 1);

  localparam logic [1:0]        FACE_LAST = 2'(NUM_FACES - 1);
  localparam logic [2:0]        FILT_LAST = 3'(NUM_FILTERS - 1);
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(AUTO_FRAMES - 1);
  localparam logic [HANG_W-1:0] HANG_LOAD = HANG_W'(MIC_HANG);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t             state_reg,    state_next;
  logic [1:0]         face_reg,     face_next;
  logic [2:0]         filt_reg,     filt_next;
  logic               mic_en_reg,   mic_en_next;
  logic               tick_reg,     tick_next;
  logic               synced_reg,   synced_next;
  logic               pf_face_reg,  pf_face_next;
  logic               pf_filt_reg,  pf_filt_next;
  logic               mic_seen_reg, mic_seen_next;
  logic [FC_W-1:0]    fc_reg,       fc_next;
  logic [HANG_W-1:0]  hang_reg,     hang_next;

  // Frame boundary: the accepted end-of-packet beat.
  logic boundary;
  assign boundary = vid_eop & vid_valid & vid_ready;

  // A request arriving in the same cycle as the boundary counts for that boundary.
  logic face_req_any;
  logic filt_req_any;
  logic auto_due;
  assign face_req_any = pf_face_reg | req_face;
  assign filt_req_any = pf_filt_reg | req_filter;
  assign auto_due     = auto_en & (fc_reg == FC_LAST);

  // Wrapping increments that never visit codes outside the legal range.
  logic [1:0]        face_inc;
  logic [2:0]        filt_inc;
  logic [HANG_W-1:0] hang_dec;
  assign face_inc = (face_reg == FACE_LAST) ? 2'd0 : face_reg + 2'd1;
  assign filt_inc = (filt_reg == FILT_LAST) ? 3'd0 : filt_reg + 3'd1;
  assign hang_dec = (hang_reg != '0) ? hang_reg - HANG_W'(1) : hang_reg;

  // Next-state and output logic for the scheduler FSM.
  always_comb begin
    state_next    = state_reg;
    face_next     = face_reg;
    filt_next     = filt_reg;
    mic_en_next   = mic_en_reg;
    synced_next   = synced_reg;
    pf_face_next  = pf_face_reg;
    pf_filt_next  = pf_filt_reg;
    fc_next       = fc_reg;
    hang_next     = hang_reg;
    tick_next     = boundary;
    // Sticky mic activity for the current frame, consumed at every boundary.
    mic_seen_next = boundary ? 1'b0 : (mic_seen_reg | mic_active);

    // The auto counter is meaningless while auto-cycling is off.
    if (!auto_en) begin
      fc_next = '0;
    end

    case (state_reg)
      SYNC: begin
        // Requests are ignored until we know where frames start.
        pf_face_next = 1'b0;
        pf_filt_next = 1'b0;
        if (boundary) begin
          state_next  = RUN;
          synced_next = 1'b1;
        end
      end

      RUN, PEND: begin
        if (boundary) begin
          // Manual and auto advances at the same boundary merge into one step.
          if (face_req_any | auto_due) begin
            face_next = face_inc;
          end
          if (filt_req_any) begin
            filt_next = filt_inc;
          end
          if (auto_en) begin
            fc_next = (face_req_any | auto_due) ? '0 : fc_reg + FC_W'(1);
          end
          if (face_req_any) begin
            fc_next = '0;
          end
          // Mic hang: reload on activity, otherwise count boundaries down.
          if (mic_seen_reg | mic_active) begin
            mic_en_next = 1'b1;
            hang_next   = HANG_LOAD;
          end else begin
            hang_next   = hang_dec;
            mic_en_next = (hang_dec != '0);
          end
          pf_face_next = 1'b0;
          pf_filt_next = 1'b0;
          state_next   = RUN;
        end else begin
          // Coalesce any number of requests within the frame into one flag.
          pf_face_next = face_req_any;
          pf_filt_next = filt_req_any;
          if (face_req_any | filt_req_any) begin
            state_next = PEND;
          end
        end
      end

      default: begin
        state_next = SYNC;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= SYNC;
      face_reg     <= 2'd0;
      filt_reg     <= 3'd0;
      mic_en_reg   <= 1'b0;
      tick_reg     <= 1'b0;
      synced_reg   <= 1'b0;
      pf_face_reg  <= 1'b0;
      pf_filt_reg  <= 1'b0;
      mic_seen_reg <= 1'b0;
      fc_reg       <= '0;
      hang_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      face_reg     <= face_next;
      filt_reg     <= filt_next;
      mic_en_reg   <= mic_en_next;
      tick_reg     <= tick_next;
      synced_reg   <= synced_next;
      pf_face_reg  <= pf_face_next;
      pf_filt_reg  <= pf_filt_next;
      mic_seen_reg <= mic_seen_next;
      fc_reg       <= fc_next;
      hang_reg     <= hang_next;
    end
  end

  assign face_select = face_reg;
  assign filter_mode = filt_reg;
  assign mic_en      = mic_en_reg;
  assign frame_tick  = tick_reg;
  assign synced      = synced_reg;

endmodule

// File: tb/tb_face_ctrl_sched.sv
// Directed testbench for face_ctrl_sched (AUTO_FRAMES overridden to 2).
module tb_face_ctrl_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_face = 1'b0;
  logic       req_filter = 1'b0;
  logic       auto_en = 1'b0;
  logic       mic_active = 1'b0;
  logic       vid_eop = 1'b0;
  logic       vid_valid = 1'b0;
  logic       vid_ready = 1'b0;
  logic [1:0] face_select;
  logic [2:0] filter_mode;
  logic       mic_en;
  logic       frame_tick;
  logic       synced;

  int tests_run = 0;
  int tests_failed = 0;
  int tick_count = 0;

  face_ctrl_sched #(
    .NUM_FACES  (3),
    .NUM_FILTERS(3),
    .AUTO_FRAMES(2),
    .MIC_HANG   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_face   (req_face),
    .req_filter (req_filter),
    .auto_en    (auto_en),
    .mic_active (mic_active),
    .vid_eop    (vid_eop),
    .vid_valid  (vid_valid),
    .vid_ready  (vid_ready),
    .face_select(face_select),
    .filter_mode(filter_mode),
    .mic_en     (mic_en),
    .frame_tick (frame_tick),
    .synced     (synced)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, then sample outputs 1 time unit after the edge.
  task automatic cyc(input logic eop, input logic valid, input logic ready,
                     input logic rf, input logic rfl, input logic mic);
    vid_eop    = eop;
    vid_valid  = valid;
    vid_ready  = ready;
    req_face   = rf;
    req_filter = rfl;
    mic_active = mic;
    @(posedge clk);
    #1;
    if (frame_tick === 1'b1) tick_count++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bnd();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (face_select !== 2'd0) begin tests_failed++; $display("FAIL reset_face: got %0d want 0", face_select); end
    tests_run++;
    if (filter_mode !== 3'd0) begin tests_failed++; $display("FAIL reset_filter: got %0d want 0", filter_mode); end
    tests_run++;
    if (mic_en !== 1'b0) begin tests_failed++; $display("FAIL reset_mic: got %b want 0", mic_en); end
    tests_run++;
    if (frame_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    tests_run++;
    if (synced !== 1'b0) begin tests_failed++; $display("FAIL reset_synced: got %b want 0", synced); end
    reset = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_sync_frames();
    int t0;
    t0 = tick_count;
    idle(1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   // discarded while unsynced
    idle(1);
    tests_run++;
    if (synced !== 1'b0) begin tests_failed++; $display("FAIL sync_before: got %b want 0", synced); end
    bnd();
    tests_run++;
    if (synced !== 1'b1) begin tests_failed++; $display("FAIL sync_after: got %b want 1", synced); end
    tests_run++;
    if (frame_tick !== 1'b1) begin tests_failed++; $display("FAIL sync_tick: got %b want 1", frame_tick); end
    tests_run++;
    if (face_select !== 2'd0 || filter_mode !== 3'd0) begin
      tests_failed++; $display("FAIL sync_noadv: face=%0d filt=%0d want 0/0", face_select, filter_mode);
    end
    idle(1);
    tests_run++;
    if (frame_tick !== 1'b0) begin tests_failed++; $display("FAIL tick_width: got %b want 0", frame_tick); end
    for (int f = 0; f < 2; f++) begin
      idle(2);
      bnd();
    end
    tests_run++;
    if (tick_count - t0 !== 3) begin tests_failed++; $display("FAIL tick_count: got %0d want 3", tick_count - t0); end
    tests_run++;
    if (face_select !== 2'd0 || filter_mode !== 3'd0 || mic_en !== 1'b0) begin
      tests_failed++; $display("FAIL idle_outputs: face=%0d filt=%0d mic=%b want 0/0/0", face_select, filter_mode, mic_en);
    end
    $display("[TB] sync frames: ticks=%0d face=%0d filt=%0d", tick_count - t0, face_select, filter_mode);
  endtask

  task automatic test_face_coalesce();
    idle(1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
      tests_run++;
      if (face_select !== 2'd0) begin tests_failed++; $display("FAIL coalesce_pre%0d: got %0d want 0", i, face_select); end
    end
    bnd();
    tests_run++;
    if (face_select !== 2'd1) begin tests_failed++; $display("FAIL coalesce_adv: got %0d want 1", face_select); end
    idle(2);
    tests_run++;
    if (face_select !== 2'd1) begin tests_failed++; $display("FAIL coalesce_hold: got %0d want 1", face_select); end
    $display("[TB] face coalesce: face=%0d", face_select);
  endtask

  task automatic test_stall_filter();
    logic [2:0] exp_filt [4];
    exp_filt = '{3'd2, 3'd0, 3'd1, 3'd2};
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // eop without valid
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (filter_mode !== 3'd0 || frame_tick !== 1'b0) begin
        tests_failed++; $display("FAIL stall%0d: filt=%0d tick=%b want 0/0", i, filter_mode, frame_tick);
      end
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (filter_mode !== 3'd1) begin tests_failed++; $display("FAIL stall_accept: got %0d want 1", filter_mode); end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(1);
      bnd();
      tests_run++;
      if (filter_mode !== exp_filt[i]) begin
        tests_failed++; $display("FAIL filter_seq%0d: got %0d want %0d", i, filter_mode, exp_filt[i]);
      end
    end
    tests_run++;
    if (face_select !== 2'd1) begin tests_failed++; $display("FAIL filter_face_stable: got %0d want 1", face_select); end
    $display("[TB] stall/filter: filt=%0d", filter_mode);
  endtask

  task automatic test_same_cycle();
    idle(1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (face_select !== 2'd2) begin tests_failed++; $display("FAIL same_cycle: got %0d want 2", face_select); end
    $display("[TB] same-cycle request: face=%0d", face_select);
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (face_select !== 2'd0 || frame_tick !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_1: face=%0d tick=%b want 0/1", face_select, frame_tick);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (face_select !== 2'd1 || filter_mode !== 3'd0 || frame_tick !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_2: face=%0d filt=%0d tick=%b want 1/0/1", face_select, filter_mode, frame_tick);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (face_select !== 2'd1 || filter_mode !== 3'd0) begin
      tests_failed++; $display("FAIL b2b_3: face=%0d filt=%0d want 1/0", face_select, filter_mode);
    end
    $display("[TB] back-to-back: face=%0d filt=%0d", face_select, filter_mode);
  endtask

  task automatic test_auto();
    logic [1:0] exp_face [7];
    exp_face = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
    auto_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      idle(1);
      bnd();
      tests_run++;
      if (face_select !== exp_face[i]) begin
        tests_failed++; $display("FAIL auto_seq%0d: got %0d want %0d", i, face_select, exp_face[i]);
      end
    end
    idle(1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // manual request on an auto-due boundary
    tests_run++;
    if (face_select !== 2'd2) begin tests_failed++; $display("FAIL auto_merge: got %0d want 2", face_select); end
    idle(1);
    bnd();
    tests_run++;
    if (face_select !== 2'd2) begin tests_failed++; $display("FAIL auto_fc1: got %0d want 2", face_select); end
    auto_en = 1'b0;
    idle(1);
    auto_en = 1'b1;
    idle(1);
    bnd();
    tests_run++;
    if (face_select !== 2'd2) begin tests_failed++; $display("FAIL auto_fc_clear: got %0d want 2", face_select); end
    idle(1);
    bnd();
    tests_run++;
    if (face_select !== 2'd0) begin tests_failed++; $display("FAIL auto_after_clear: got %0d want 0", face_select); end
    auto_en = 1'b0;
    $display("[TB] auto cycle: face=%0d", face_select);
  endtask

  task automatic test_mic();
    logic exp_mic [4];
    exp_mic = '{1'b1, 1'b1, 1'b1, 1'b0};
    idle(1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    tests_run++;
    if (mic_en !== 1'b0) begin tests_failed++; $display("FAIL mic_pre: got %b want 0", mic_en); end
    bnd();
    tests_run++;
    if (mic_en !== 1'b1) begin tests_failed++; $display("FAIL mic_b1: got %b want 1", mic_en); end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      bnd();
      tests_run++;
      if (mic_en !== exp_mic[i]) begin
        tests_failed++; $display("FAIL mic_b%0d: got %b want %b", i + 2, mic_en, exp_mic[i]);
      end
    end
    $display("[TB] mic hang: mic_en=%b", mic_en);
  endtask

  task automatic test_reset_pend();
    idle(1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    bnd();
    tests_run++;
    if (face_select !== 2'd1 || filter_mode !== 3'd1 || mic_en !== 1'b1) begin
      tests_failed++; $display("FAIL rp_setup: face=%0d filt=%0d mic=%b want 1/1/1", face_select, filter_mode, mic_en);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (face_select !== 2'd0 || filter_mode !== 3'd0 || mic_en !== 1'b0 || synced !== 1'b0) begin
      tests_failed++; $display("FAIL rp_async: face=%0d filt=%0d mic=%b synced=%b want 0/0/0/0",
                               face_select, filter_mode, mic_en, synced);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    bnd();
    tests_run++;
    if (synced !== 1'b1 || face_select !== 2'd0 || filter_mode !== 3'd0) begin
      tests_failed++; $display("FAIL rp_resync: synced=%b face=%0d filt=%0d want 1/0/0", synced, face_select, filter_mode);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    bnd();
    tests_run++;
    if (face_select !== 2'd1 || filter_mode !== 3'd0) begin
      tests_failed++; $display("FAIL rp_adv: face=%0d filt=%0d want 1/0", face_select, filter_mode);
    end
    $display("[TB] reset in pend: face=%0d filt=%0d", face_select, filter_mode);
  endtask

  initial begin
    test_reset();
    test_sync_frames();
    test_face_coalesce();
    test_stall_filter();
    test_same_cycle();
    test_back_to_back();
    test_auto();
    test_mic();
    test_reset_pend();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
